// File: rtl/tpu_sequencer.sv
// tpu_sequencer: host-side instruction issuer for the Mini TPU control unit.
// It streams matrices A and B in as LOAD instructions and issues START. It
// then waits out the systolic computation and reads every result cell back
// with a STORE, returning each result byte on a valid/ready output stream.
// The instruction output is registered. Each state computes the word that
// drives the control unit during the following cycle.
// Optional build macro: TPU_SEQ_STOP_EN inserts a one-cycle STOP (16'h4000)
// between the compute wait and the first STORE.
module tpu_sequencer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned COMPUTE_CYCLES = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [15:0]           instruction,
  input  logic [DATA_WIDTH-1:0] array_result,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [15:0] InstrNop   = 16'hC000;  // STORE r0 c0, harmless to the array
  localparam logic [15:0] InstrStart = 16'h0000;
  localparam logic [15:0] InstrStop  = 16'h4000;
  localparam logic [1:0]  OpLoad     = 2'b10;
  localparam logic [1:0]  OpStore    = 2'b11;

  localparam int unsigned WaitW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(COMPUTE_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StStart,
    StWait,
    StStop,
    StStoreIssue,
    StStoreCap,
    StStoreOut
  } state_e;

  state_e                  r_state, w_state_next;
  logic [3:0]              r_idx, w_idx_next;
  logic [WaitW-1:0]        r_wait, w_wait_next;
  logic [15:0]             r_instr, w_instr_next;
  logic [DATA_WIDTH-1:0]   r_out_data, w_out_data_next;
  logic                    r_out_valid, w_out_valid_next;
  logic                    r_done, w_done_next;

  logic                    w_in_hs;
  logic                    w_out_hs;
  logic [7:0]              w_imm;

  assign in_ready    = (r_state == StLoadA) || (r_state == StLoadB);
  assign busy        = (r_state != StIdle);
  assign done        = r_done;
  assign instruction = r_instr;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;

  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;
  assign w_imm    = 8'(in_data);

  // State, index, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_wait      <= '0;
      r_instr     <= InstrNop;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_wait      <= w_wait_next;
      r_instr     <= w_instr_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_done      <= w_done_next;
    end
  end

  // Next-state logic and the instruction to present on the following cycle.
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_wait_next      = r_wait;
    w_instr_next     = r_instr;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    w_done_next      = 1'b0;

    case (r_state)
      StIdle: begin
        w_instr_next = InstrNop;
        w_idx_next   = '0;
        if (start) begin
          w_state_next = StLoadA;
        end
      end

      StLoadA: begin
        w_instr_next = InstrNop;
        if (w_in_hs) begin
          w_instr_next = {OpLoad, 1'b0, 1'b0, r_idx[3:2], r_idx[1:0], w_imm};
          w_idx_next   = r_idx + 4'd1;  // wraps to 0 for the B phase
          if (r_idx == 4'd15) begin
            w_state_next = StLoadB;
          end
        end
      end

      StLoadB: begin
        w_instr_next = InstrNop;
        if (w_in_hs) begin
          w_instr_next = {OpLoad, 1'b1, 1'b0, r_idx[3:2], r_idx[1:0], w_imm};
          w_idx_next   = r_idx + 4'd1;  // wraps to 0 for the readback phase
          if (r_idx == 4'd15) begin
            w_state_next = StStart;
          end
        end
      end

      StStart: begin
        w_instr_next = InstrStart;
        w_wait_next  = '0;
        w_state_next = StWait;
      end

      StWait: begin
        w_instr_next = InstrNop;
        if (r_wait == WaitLast) begin
`ifdef TPU_SEQ_STOP_EN
          w_state_next = StStop;
`else
          w_state_next = StStoreIssue;
`endif
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end

`ifdef TPU_SEQ_STOP_EN
      StStop: begin
        w_instr_next = InstrStop;
        w_state_next = StStoreIssue;
      end
`endif

      StStoreIssue: begin
        w_instr_next = {OpStore, 1'b0, 1'b0, r_idx[3:2], r_idx[1:0], 8'h00};
        w_state_next = StStoreCap;
      end

      // The STORE is on the bus this cycle, so array_result is the selected cell.
      StStoreCap: begin
        w_out_data_next  = array_result;
        w_out_valid_next = 1'b1;
        w_state_next     = StStoreOut;
      end

      // Hold the result and the STORE until the consumer takes the byte.
      StStoreOut: begin
        if (w_out_hs) begin
          w_out_valid_next = 1'b0;
          if (r_idx == 4'd15) begin
            w_done_next  = 1'b1;
            w_idx_next   = '0;
            w_instr_next = InstrNop;
            w_state_next = StIdle;
          end else begin
            w_idx_next   = r_idx + 4'd1;
            w_state_next = StStoreIssue;
          end
        end
      end

      default: begin
        w_instr_next = InstrNop;
        w_state_next = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer. It models the systolic array as a lookup
// of the bench-computed product C = A*B addressed by the STORE on the
// instruction bus. Define TPU_SEQ_STOP_EN to match a STOP-enabled build.
module tb_tpu_sequencer;

  localparam int CC = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instruction;
  logic [7:0]  array_result;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_a [16];
  logic [7:0]  m_b [16];
  logic [7:0]  m_c [16];

  logic [15:0] instr_log [$];
  logic [7:0]  out_log [$];
  int          done_cnt = 0;
  int          log_base = 0;
  int          out_base = 0;
  int          done_base = 0;

  always #5 clk = ~clk;

  tpu_sequencer #(
    .DATA_WIDTH    (8),
    .COMPUTE_CYCLES(CC)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .array_result(array_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Array model: the cell selected by the STORE currently on the bus.
  always_comb begin
    array_result = 8'h00;
    if (instruction[15:14] == 2'b11) array_result = m_c[instruction[11:8]];
  end

  // Log the instruction stream while busy, plus result handshakes and done pulses.
  always @(negedge clk) begin
    if (busy) instr_log.push_back(instruction);
    if (out_valid && out_ready) out_log.push_back(out_data);
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int mode);
    int acc;
    for (int k = 0; k < 16; k++) begin
      case (mode)
        0: begin m_a[k] = 8'(k + 1); m_b[k] = ((k % 5) == 0) ? 8'd1 : 8'd0; end
        1: begin m_a[k] = 8'(k * 7 + 3); m_b[k] = 8'(k * 5 + 1); end
        2: begin m_a[k] = 8'(k + 16); m_b[k] = 8'(2 * k + 1); end
        default: begin m_a[k] = 8'(200 - k * 9); m_b[k] = 8'(k * 11 + 4); end
      endcase
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        acc = 0;
        for (int j = 0; j < 4; j++) acc += int'(m_a[r * 4 + j]) * int'(m_b[j * 4 + c]);
        m_c[r * 4 + c] = 8'(acc);
      end
    end
  endtask

  task automatic start_job();
    log_base  = instr_log.size();
    out_base  = out_log.size();
    done_base = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input bit gaps, input int n);
    int k = 0;
    int guard = 0;
    bit phase = 1'b0;
    bit hs;
    while (k < n && guard < 400) begin
      if (gaps && phase) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        if (k < 16) in_data = m_a[k];
        else in_data = m_b[k - 16];
      end
      hs = in_valid && in_ready;
      tick();
      if (hs) k++;
      phase = ~phase;
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL feed: accepted %0d elements, required %0d", k, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cnt == done_base && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (done_cnt == done_base) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    tick();
  endtask

  // Checks the logged stream of the last job against A, B and C.
  task automatic check_job_logs(input string name);
    int z = -1;
    int nz = 0;
    int nload = 0;
    int nstop = 0;
    int bad = 0;
    int nnop = 0;
    int s;
    logic [15:0] v;
    logic [15:0] exp;
    logic [7:0]  elem;
    logic [15:0] prev;
    logic [15:0] dd [$];
    for (int i = log_base; i < instr_log.size(); i++) begin
      v = instr_log[i];
      if (v == 16'h0000) begin
        nz++;
        if (z < 0) z = i;
      end
      if (v[15:14] == 2'b01) nstop++;
      if (v[15:14] == 2'b10) begin
        if (nload < 16) elem = m_a[nload];
        else elem = m_b[(nload - 16) % 16];
        exp = {2'b10, (nload >= 16), 1'b0, 4'(nload), elem};
        checks++;
        if (v !== exp) begin
          errors++;
          $display("FAIL %s load%0d: got %h, expected %h", name, nload, v, exp);
        end
        nload++;
      end else if (z < 0 && v !== 16'hC000) begin
        bad++;
      end
    end
    checks++;
    if (nload != 32) begin
      errors++;
      $display("FAIL %s load_count: got %0d, expected 32", name, nload);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s load_gap_nop: %0d non-NOP gap words, expected 0", name, bad);
    end
    checks++;
    if (nz != 1) begin
      errors++;
      $display("FAIL %s start_count: got %0d, expected 1", name, nz);
    end
`ifdef TPU_SEQ_STOP_EN
    checks++;
    if (nstop != 1) begin
      errors++;
      $display("FAIL %s stop_count: got %0d, expected 1", name, nstop);
    end
    s = z + CC + 2;
`else
    checks++;
    if (nstop != 0) begin
      errors++;
      $display("FAIL %s stop_count: got %0d, expected 0", name, nstop);
    end
    s = z + 1;
`endif
    if (z >= 0 && s < instr_log.size()) begin
      for (int i = z + 1; i <= z + CC; i++) if (instr_log[i] === 16'hC000) nnop++;
      checks++;
      if (nnop != CC) begin
        errors++;
        $display("FAIL %s wait_nops: got %0d NOPs after START, expected %0d", name, nnop, CC);
      end
`ifdef TPU_SEQ_STOP_EN
      checks++;
      if (instr_log[z + CC + 1] !== 16'h4000) begin
        errors++;
        $display("FAIL %s stop_slot: got %h, expected 4000", name, instr_log[z + CC + 1]);
      end
`endif
      prev = 16'hFFFF;
      for (int i = s; i < instr_log.size(); i++) begin
        if (instr_log[i] !== prev) dd.push_back(instr_log[i]);
        prev = instr_log[i];
      end
      checks++;
      if (dd.size() != 16) begin
        errors++;
        $display("FAIL %s store_count: got %0d distinct STORE words, expected 16", name, dd.size());
      end else begin
        for (int k = 0; k < 16; k++) begin
          exp = {4'hC, 4'(k), 8'h00};
          checks++;
          if (dd[k] !== exp) begin
            errors++;
            $display("FAIL %s store%0d: got %h, expected %h", name, k, dd[k], exp);
          end
        end
      end
    end else begin
      checks++;
      errors++;
      $display("FAIL %s start_missing: START not found or stream too short", name);
    end
    checks++;
    if (out_log.size() - out_base != 16) begin
      errors++;
      $display("FAIL %s result_count: got %0d, expected 16", name, out_log.size() - out_base);
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (out_log[out_base + k] !== m_c[k]) begin
          errors++;
          $display("FAIL %s result%0d: got %h, expected %h", name, k, out_log[out_base + k],
                   m_c[k]);
        end
      end
    end
    checks++;
    if (done_cnt - done_base != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt - done_base);
    end
  endtask

  task automatic test_reset();
    logic [28:0] obs;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      obs = {instruction, busy, in_ready, out_valid, done, out_data, 1'b0};
      checks++;
      if (obs !== {16'hC000, 4'b0000, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cycle%0d: instr=%h busy=%b in_ready=%b out_valid=%b done=%b",
                 c, instruction, busy, in_ready, out_valid, done);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_start: busy=%b in_ready=%b, expected 1 1", busy, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || instruction !== 16'hC000) begin
      errors++;
      $display("FAIL reset_async: busy=%b instr=%h, expected 0 C000", busy, instruction);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_job();
    int n = 0;
    set_data(0);
    out_ready = 1'b1;
    start_job();
    feed(1'b0, 32);
    wait_done(200);
    for (int i = log_base; i < instr_log.size(); i++) begin
      if (instr_log[i][15:14] == 2'b10) begin
        if (n == 0 || n == 6 || n == 16) begin
          checks++;
          if (instr_log[i] !== ((n == 0) ? 16'h8001 : (n == 6) ? 16'h8607 : 16'hA001)) begin
            errors++;
            $display("FAIL full_job spot_load%0d: got %h", n, instr_log[i]);
          end
        end
        n++;
      end
    end
    check_job_logs("full_job");
  endtask

  task automatic test_valid_gaps();
    set_data(1);
    out_ready = 1'b1;
    start_job();
    feed(1'b1, 32);
    wait_done(200);
    check_job_logs("valid_gaps");
  endtask

  task automatic test_out_stall();
    int c;
    set_data(2);
    out_ready = 1'b0;
    start_job();
    feed(1'b0, 32);
    for (int k = 0; k < 16; k++) begin
      c = 0;
      while (out_valid !== 1'b1 && c < 50) begin
        tick();
        c++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_stall valid%0d: out_valid never rose", k);
      end
      if (k == 3) begin
        for (int w = 0; w < 5; w++) begin
          tick();
          checks++;
          if (out_valid !== 1'b1 || out_data !== m_c[3] || instruction !== 16'hC300) begin
            errors++;
            $display("FAIL out_stall hold%0d: valid=%b data=%h instr=%h, expected 1 %h C300",
                     w, out_valid, out_data, instruction, m_c[3]);
          end
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    wait_done(50);
    check_job_logs("out_stall");
  endtask

  task automatic test_start_and_reset_abort();
    int c = 0;
    set_data(3);
    out_ready = 1'b1;
    start_job();
    feed(1'b0, 32);
    while (instruction !== 16'h0000 && c < 10) begin
      tick();
      c++;
    end
    tick();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || instruction !== 16'hC000) begin
      errors++;
      $display("FAIL start_in_wait: busy=%b instr=%h, expected 1 C000", busy, instruction);
    end
    wait_done(200);
    check_job_logs("start_in_wait");

    set_data(1);
    start_job();
    feed(1'b0, 20);
    rst_n = 1'b0;
    #1;
    checks++;
    if (instruction !== 16'hC000 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
    begin
      errors++;
      $display("FAIL abort_reset: instr=%h busy=%b in_ready=%b out_valid=%b", instruction, busy,
               in_ready, out_valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (instruction !== 16'hC000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: instr=%h busy=%b, expected C000 0", instruction, busy);
    end
    set_data(2);
    start_job();
    feed(1'b0, 32);
    wait_done(200);
    check_job_logs("after_abort");
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_valid_gaps();
    test_out_stall();
    test_start_and_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
Host-side instruction issuer for the Mini TPU control unit; it is the initiator that produces the 16-bit instruction stream the control unit decodes.
- Accepts a 4x4 matrix A and a 4x4 matrix B as a byte stream and emits one LOAD per element.
- Issues START, waits out the systolic computation, then issues one STORE per result cell and returns each result byte on an output stream.
- Sits between the host/IO wrapper and the control unit plus systolic array.

Parameters:
DATA_WIDTH, 8, element width; must equal the immediate field width.
COMPUTE_CYCLES, 12, NOP cycles issued after START before the first STORE.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin a job; sampled only in IDLE
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last result handshake
in_data  input  DATA_WIDTH  matrix element byte; A then B, each row-major
in_valid  input  1  in_data valid
in_ready  output  1  sequencer accepts in_data
instruction  output  16  registered instruction to the control unit
array_result  input  DATA_WIDTH  array cell selected by the current STORE
out_data  output  DATA_WIDTH  result byte, row-major
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data

Behaviour:
Instruction encoding:
- Opcode [15:14]: LOAD=10, STORE=11, START=00, STOP=01.
- [13] memory select, 0 = A, 1 = B. [12] is always 0.
- [11:10] row, [9:8] col, [7:0] immediate.
- NOP is 16'hC000 (STORE r0 c0). 16'h0000 is START and must never appear except in the START state.

Reset values: instruction=16'hC000; busy=0; done=0; in_ready=0; out_valid=0; out_data=0; state IDLE; idx=0.
- A reset mid-job aborts immediately; the next job restarts cleanly.

Index: idx is 4-bit, row=idx[3:2], col=idx[1:0]. It wraps 15 -> 0 on each phase change.

States:
- IDLE
  - in_ready=0; instruction=NOP.
  - start=1 -> LOAD_A.
- LOAD_A
  - in_ready=1.
  - On in_valid&&in_ready, the next-cycle instruction is {10,0,0,row,col,in_data}, and idx increments.
  - A cycle with no handshake issues NOP.
  - Handshake at idx=15 -> LOAD_B.
- LOAD_B
  - Same as LOAD_A but bit13=1, i.e. {10,1,0,row,col,in_data}, where row = the matrix row index of B and col = its column index.
  - Handshake at idx=15 -> START_S.
- START_S
  - in_ready=0; instruction=16'h0000 for exactly one cycle.
  - -> WAIT with the wait counter at 0.
- WAIT
  - NOP for COMPUTE_CYCLES cycles -> STORE_ISSUE.
- STORE_ISSUE
  - instruction={11,0,0,row,col,8'h00}, held through the matching capture.
  - -> STORE_CAP.
- STORE_CAP
  - Captures array_result into out_data; out_valid=1; instruction unchanged.
  - -> STORE_OUT.
- STORE_OUT
  - out_valid held and out_data stable until out_ready.
  - On handshake: out_valid=0.
  - If idx=15: done=1 for one cycle, -> IDLE.
  - Else: idx+1, -> STORE_ISSUE.

Boundary rules:
- start asserted while busy is ignored.
- in_data is never accepted outside LOAD_A/LOAD_B.
- The START opcode is issued exactly once per job.
- in_valid gaps only stretch the load phases.
- out_ready low stalls indefinitely without reissuing instructions.
- done and start coinciding in the same cycle: the job starts on the next IDLE cycle where start=1. done is registered, so an IDLE-cycle start is accepted.

Optional Feature:
TPU_SEQ_STOP_EN
- Defined: a STOP_S state is inserted between WAIT and STORE_ISSUE. It issues 16'h4000 for one cycle, forcing the control unit idle before readback.
- Undefined: WAIT goes directly to STORE_ISSUE and opcode 01 is never emitted.

Test Plan:
1. Reset with no stimulus -> instruction=16'hC000, busy=0, in_ready=0, out_valid=0 for 20 cycles; start=1 -> busy=1 next cycle.
2. Full job, A=1..16, B=identity, in_valid always 1, out_ready always 1:
   - First instruction 16'h8001; A[1][2]=7 -> 16'h8607; first B element -> 16'hA001.
   - Exactly one 16'h0000, followed by 12 cycles of 16'hC000, then 16'hC000, 16'hC100 ... 16'hCF00.
   - out_data equals the model array values in row-major order; done pulses once.
3. in_valid toggling 1/0 during loads -> exactly 32 LOAD instructions, NOP in the gap cycles, immediates in stream order.
4. out_ready held low for 5 cycles on result 3 -> out_data and instruction 16'hC300 stable, no extra STORE; release -> sequence resumes.
5. start pulsed during WAIT, and rst_n pulsed low mid-LOAD_B -> start ignored; after reset, instruction=16'hC000 and IDLE; a new job from idx 0 completes correctly.
6. With TPU_SEQ_STOP_EN -> exactly one 16'h4000, directly after the 12 NOPs and before 16'hC000.
